fib_lookup_arb: RTL and testbench
=================================

// Module: fib_lookup_arb
// PURPOSE
//  Shares the single FIB lookup engine between the bridge's NUM_PORTS ingress ports.
//  Arbitrates lookup requests round-robin and issues one request at a time.
//  Returns each result to the requesting port with the source-port bit cleared.
//  Substitutes a flood result when the engine fails to answer within TIMEOUT cycles.
//  Sits between the per-port rx parsers and the FIB, on the core clk domain.
// PARAMETERS
//  NUM_PORTS  4    number of requesting ports (2..8)
//  REQ_W      96   lookup payload width ({DA[47:0],SA[47:0]})
//  TIMEOUT    255  max cycles in WAIT before flood substitution (1..65535)
// PORTS
//  clk        in   1                  core clock
//  reset      in   1                  synchronous, active-low (0 = reset)
//  p_srdy     in   NUM_PORTS          per-port request valid
//  p_req      in   NUM_PORTS*REQ_W    per-port payload; port i in [i*REQ_W +: REQ_W]
//  p_drdy     out  NUM_PORTS          per-port request accepted
//  lk_srdy    out  1                  request valid to FIB
//  lk_req     out  REQ_W              payload to FIB
//  lk_src     out  clog2(NUM_PORTS)   source port number to FIB
//  lk_drdy    in   1                  FIB accepts request
//  lr_srdy    in   1                  FIB result valid
//  lr_res     in   NUM_PORTS          FIB destination port mask
//  lr_drdy    out  1                  arbiter accepts result
//  r_srdy     out  NUM_PORTS          per-port result valid (one-hot or zero)
//  r_res      out  NUM_PORTS          destination mask returned to the granted port
//  r_drdy     in   NUM_PORTS          per-port result accepted
//  err_to     out  1                  one-cycle pulse on timeout
// BEHAVIOUR
//  - Handshakes: srdy/drdy; a transfer occurs on a cycle with srdy&drdy=1.
//    - Requesters hold p_srdy and p_req stable until accepted.
//  - Reset (reset==0 at posedge clk): state=IDLE, rr_ptr=0, grant=0, timer=0.
//    - All outputs are 0: p_drdy, lk_srdy, lr_drdy, r_srdy, r_res, err_to.
//    - Reset mid-operation abandons the transaction. No result is returned for it.
//  - FSM states: IDLE, ISSUE, WAIT, RETURN.
//  - IDLE:
//    - Scan p_srdy starting at rr_ptr, wrapping modulo NUM_PORTS.
//    - On the first set bit, latch grant and go to ISSUE.
//    - If no bit is set, stay in IDLE.
//  - ISSUE:
//    - lk_srdy=1; lk_req=p_req[grant]; lk_src=grant.
//    - p_drdy[grant]=lk_drdy; all other p_drdy bits are 0.
//    - On lk_srdy&lk_drdy, clear timer and go to WAIT.
//    - Minimum latency from p_srdy rise (in IDLE) to lk_srdy is 1 cycle.
//  - WAIT:
//    - lr_drdy=1; timer increments each cycle.
//    - If lr_srdy=1: res_q = lr_res & ~(1<<grant); go to RETURN.
//    - Else if timer==TIMEOUT-1: res_q = all-ones & ~(1<<grant); err_to=1 for 1 cycle; go to RETURN.
//    - If lr_srdy and timeout occur on the same cycle, lr_srdy wins and err_to stays 0.
//  - RETURN:
//    - r_srdy[grant]=1; r_res=res_q; lr_drdy=0.
//    - On r_drdy[grant], set rr_ptr=(grant+1) mod NUM_PORTS and go to IDLE.
//  - lr_srdy outside WAIT: lr_drdy is 0, so the result is not consumed and is not an error.
//  - At most one transaction is outstanding. Arbitration is work-conserving, with no idle cycles beyond the IDLE decision.
//  - Fairness: a port with p_srdy held high is granted within NUM_PORTS transactions.
// TESTING
//  1 Reset: hold reset=0 for 3 clks while p_srdy=4'hF -> all outputs 0. After release, the first grant is port 0.
//  2 Round-robin: p_srdy=4'hF held, FIB answers in 2 cycles -> grants in order 0,1,2,3,0; lk_src matches each.
//  3 Source mask: port 2 requests, lr_res=4'b0111 -> r_srdy=4'b0100, r_res=4'b0011.
//  4 Timeout: TIMEOUT=8, FIB never returns, port 1 requests -> err_to pulses on WAIT cycle 8; r_res=4'b1101.
//  5 Backpressure: lk_drdy=0 for 5 cycles, then r_drdy[3]=0 for 4 cycles -> lk_req stable, r_res stable, no grant change.
//  6 Tie and reset: lr_srdy on the timeout cycle -> err_to=0, FIB result used. Reset asserted in WAIT -> IDLE, r_srdy never asserted.

Source files
------------

// File: rtl/fib_lookup_arb.sv
// Round-robin arbiter sharing one FIB lookup engine among NUM_PORTS ingress ports.
// One lookup is in flight at a time. A flood result is substituted if the FIB times out.
module fib_lookup_arb #(
    parameter int NUM_PORTS = 4,
    parameter int REQ_W     = 96,
    parameter int TIMEOUT   = 255,
    localparam int SRC_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       p_srdy,
    input  logic [NUM_PORTS*REQ_W-1:0] p_req,
    output logic [NUM_PORTS-1:0]       p_drdy,
    output logic                       lk_srdy,
    output logic [REQ_W-1:0]           lk_req,
    output logic [SRC_W-1:0]           lk_src,
    input  logic                       lk_drdy,
    input  logic                       lr_srdy,
    input  logic [NUM_PORTS-1:0]       lr_res,
    output logic                       lr_drdy,
    output logic [NUM_PORTS-1:0]       r_srdy,
    output logic [NUM_PORTS-1:0]       r_res,
    input  logic [NUM_PORTS-1:0]       r_drdy,
    output logic                       err_to
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

    state_t               state;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     grant;
    logic [SRC_W-1:0]     pick;
    logic [SRC_W-1:0]     next_ptr;
    logic                 found;
    logic [15:0]          timer;
    logic [NUM_PORTS-1:0] res_q;
    logic [NUM_PORTS-1:0] grant_mask;
    logic                 timeout_hit;

    // Walk the ports starting at rr_ptr; the first requester found wins.
    always_comb begin
        logic [SRC_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = SRC_W'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!found && p_srdy[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign grant_mask  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant;
    assign next_ptr    = (grant == SRC_W'(NUM_PORTS - 1)) ? '0 : grant + SRC_W'(1);
    assign timeout_hit = (timer == 16'(TIMEOUT - 1));

    assign lk_srdy = (state == S_ISSUE);
    assign lk_req  = p_req[grant*REQ_W +: REQ_W];
    assign lk_src  = grant;
    assign p_drdy  = (state == S_ISSUE && lk_drdy) ? grant_mask : '0;
    assign lr_drdy = (state == S_WAIT);
    assign r_srdy  = (state == S_RETURN) ? grant_mask : '0;
    assign r_res   = (state == S_RETURN) ? res_q : '0;
    // A FIB answer arriving on the timeout cycle wins, so it suppresses the error.
    assign err_to  = (state == S_WAIT) && !lr_srdy && timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            timer  <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (lk_drdy) begin
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer <= timer + 16'd1;
                    if (lr_srdy) begin
                        res_q <= lr_res & ~grant_mask;
                        state <= S_RETURN;
                    end else if (timeout_hit) begin
                        res_q <= ~grant_mask;
                        state <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    if (r_drdy[grant]) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_lookup_arb.sv
// Directed, table-driven bench for fib_lookup_arb: one vector per clock with hand-computed outputs.
// Inputs are driven 2ns after the rising edge and outputs are sampled 1ns later.
module tb_fib_lookup_arb;

    localparam int NP = 4;
    localparam int RW = 96;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    p_srdy;
    logic [NP*RW-1:0] p_req;
    logic [NP-1:0]    p_drdy;
    logic             lk_srdy;
    logic [RW-1:0]    lk_req;
    logic [1:0]       lk_src;
    logic             lk_drdy;
    logic             lr_srdy;
    logic [NP-1:0]    lr_res;
    logic             lr_drdy;
    logic [NP-1:0]    r_srdy;
    logic [NP-1:0]    r_res;
    logic [NP-1:0]    r_drdy;
    logic             err_to;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] p_srdy;
        logic       lk_drdy;
        logic       lr_srdy;
        logic [3:0] lr_res;
        logic [3:0] r_drdy;
        logic [3:0] e_p_drdy;
        logic       e_lk_srdy;
        logic [1:0] e_lk_src;
        logic       e_lr_drdy;
        logic [3:0] e_r_srdy;
        logic [3:0] e_r_res;
        logic       e_err_to;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    fib_lookup_arb #(.NUM_PORTS(NP), .REQ_W(RW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .p_srdy  (p_srdy),
        .p_req   (p_req),
        .p_drdy  (p_drdy),
        .lk_srdy (lk_srdy),
        .lk_req  (lk_req),
        .lk_src  (lk_src),
        .lk_drdy (lk_drdy),
        .lr_srdy (lr_srdy),
        .lr_res  (lr_res),
        .lr_drdy (lr_drdy),
        .r_srdy  (r_srdy),
        .r_res   (r_res),
        .r_drdy  (r_drdy),
        .err_to  (err_to)
    );

    function automatic logic [RW-1:0] payload(input int i);
        return {48'hDA00_0000_0000 + 48'(i), 48'h5A00_0000_1000 + 48'(i * 3)};
    endfunction

    function automatic vec_t mk(input int rst, input int ps, input int lkd, input int lrs,
                                input int lrr, input int rd, input int epd, input int els,
                                input int esrc, input int eld, input int ers, input int eres,
                                input int eto);
        vec_t v;
        v.rst_n     = 1'(rst);
        v.p_srdy    = 4'(ps);
        v.lk_drdy   = 1'(lkd);
        v.lr_srdy   = 1'(lrs);
        v.lr_res    = 4'(lrr);
        v.r_drdy    = 4'(rd);
        v.e_p_drdy  = 4'(epd);
        v.e_lk_srdy = 1'(els);
        v.e_lk_src  = 2'(esrc);
        v.e_lr_drdy = 1'(eld);
        v.e_r_srdy  = 4'(ers);
        v.e_r_res   = 4'(eres);
        v.e_err_to  = 1'(eto);
        return v;
    endfunction

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #2;
        reset   = v.rst_n;
        p_srdy  = v.p_srdy;
        lk_drdy = v.lk_drdy;
        lr_srdy = v.lr_srdy;
        lr_res  = v.lr_res;
        r_drdy  = v.r_drdy;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        #1;
        chk({tag, ".p_drdy"},  RW'(p_drdy),  RW'(v.e_p_drdy));
        chk({tag, ".lk_srdy"}, RW'(lk_srdy), RW'(v.e_lk_srdy));
        chk({tag, ".lr_drdy"}, RW'(lr_drdy), RW'(v.e_lr_drdy));
        chk({tag, ".r_srdy"},  RW'(r_srdy),  RW'(v.e_r_srdy));
        chk({tag, ".r_res"},   RW'(r_res),   RW'(v.e_r_res));
        chk({tag, ".err_to"},  RW'(err_to),  RW'(v.e_err_to));
        if (v.e_lk_srdy) begin
            chk({tag, ".lk_src"}, RW'(lk_src), RW'(v.e_lk_src));
            chk({tag, ".lk_req"}, lk_req, payload(int'(v.e_lk_src)));
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(v, tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants[5] = '{0, 1, 2, 3, 0};
        int onehot[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int masks[5]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        reset   = 1'b0;
        p_srdy  = 4'hF;
        lk_drdy = 1'b0;
        lr_srdy = 1'b0;
        lr_res  = '0;
        r_drdy  = '0;
        for (int i = 0; i < NP; i++) p_req[i*RW +: RW] = payload(i);

        // Reset held with busy inputs: every output stays low.
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 4'hF, 1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0));

        // Round-robin with all ports requesting and a 2-cycle FIB answer of 4'hF.
        for (int t = 0; t < 5; t++) begin
            tbl.push_back(mk(1, 4'hF, 1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(1, 4'hF, 1, 0, 0, 4'hF, onehot[t], 1, grants[t], 0, 0, 0, 0));
            tbl.push_back(mk(1, 4'hF, 1, 0, 0, 4'hF, 0, 0, 0, 1, 0, 0, 0));
            tbl.push_back(mk(1, 4'hF, 1, 1, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0));
            tbl.push_back(mk(1, 4'hF, 1, 0, 0, 4'hF, 0, 0, 0, 0, onehot[t], masks[t], 0));
        end

        // Port 2 alone, FIB returns 4'b0111; other r_drdy bits must not release it.
        tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 0, 4'b0100, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 4'b0111, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'b1011, 0, 0, 0, 0, 4'b0100, 4'b0011, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0011, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Timeout: port 1 (scan starts at 3), FIB silent, flood on the 8th WAIT cycle.
        step(mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to.idle");
        step(mk(1, 4'b0010, 1, 0, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0), "to.issue");
        for (int k = 1; k <= 8; k++)
            step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, int'(k == 8)), $sformatf("to.wait%0d", k));
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b1101, 0), "to.ret_hold");
        step(mk(1, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b1101, 0), "to.ret");

        // Backpressure: port 3 granted, lk_drdy low 5 cycles while others start requesting.
        step(mk(1, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bp.idle");
        for (int k = 1; k <= 5; k++)
            step(mk(1, 4'hF, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), $sformatf("bp.stall%0d", k));
        step(mk(1, 4'hF, 1, 0, 0, 0, 4'b1000, 1, 3, 0, 0, 0, 0), "bp.accept");
        step(mk(1, 4'b0111, 1, 1, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0), "bp.wait");
        for (int k = 1; k <= 4; k++)
            step(mk(1, 4'b0111, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 4'b1000, 4'b0111, 0),
                 $sformatf("bp.ret_stall%0d", k));
        step(mk(1, 4'b0111, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 4'b0111, 0), "bp.ret");
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bp.idle2");

        // Tie: FIB answers exactly on the timeout cycle; its result wins, no error.
        step(mk(1, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tie.idle");
        step(mk(1, 4'b0001, 1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0, 0), "tie.issue");
        for (int k = 1; k <= 7; k++)
            step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), $sformatf("tie.wait%0d", k));
        step(mk(1, 0, 1, 1, 4'b0110, 0, 0, 0, 0, 1, 0, 0, 0), "tie.wait8");
        step(mk(1, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0110, 0), "tie.ret");

        // Reset in WAIT: transaction dropped, late FIB result ignored, pointer back to 0.
        step(mk(1, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.idle");
        step(mk(1, 4'b0100, 1, 0, 0, 0, 4'b0100, 1, 2, 0, 0, 0, 0), "rst.issue");
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "rst.wait1");
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "rst.assert");
        for (int k = 1; k <= 3; k++)
            step(mk(1, 0, 1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0), $sformatf("rst.after%0d", k));
        step(mk(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.idle2");
        step(mk(1, 4'hF, 1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0, 0), "rst.regrant");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
